// File: rtl/sistema_cpu_debug_ocimem_sequencer_if.sv
// Single-beat OCI debug memory port between the monitor sequencer (master) and RAM/regfile (slave).
interface sistema_cpu_debug_ocimem_sequencer_if #(
    parameter int unsigned ADDR_W = 8
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_wr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_waitrequest;

    modport master (
        output mem_addr,
        output mem_rd,
        output mem_wr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_waitrequest
    );

    modport slave (
        input  mem_addr,
        input  mem_rd,
        input  mem_wr,
        input  mem_wdata,
        output mem_rdata,
        output mem_waitrequest
    );
endinterface

// File: rtl/sistema_cpu_debug_ocimem_sequencer.sv
// Turns decoded JTAG debug strobes into single-beat OCI memory reads/writes with address post-increment.
// Define SISTEMA_OCIMEM_TIMEOUT_EN to abort requests stalled for TIMEOUT wait-request cycles.
module sistema_cpu_debug_ocimem_sequencer #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic [37:0]                          jdo,
    input  logic                                 take_action_ocimem_a,
    input  logic                                 take_action_ocimem_b,
    input  logic                                 take_no_action_ocimem_a,
    sistema_cpu_debug_ocimem_sequencer_if.master mem,
    output logic [31:0]                          MonDReg,
    output logic                                 monitor_ready,
    output logic                                 monitor_error
);

    typedef enum logic [1:0] {StIdle, StRd, StWr} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              ready_q, ready_d;
    logic              error_q, error_d;
    logic              any_strobe;
    logic              abort;

    // Only the payload bits carrying address, data and the read flag matter.
    logic unused_jdo;
    assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

`ifdef SISTEMA_OCIMEM_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == StIdle) begin
            cnt_d = '0;
        end else if (mem.mem_waitrequest) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Abort on the TIMEOUT-th consecutive stalled cycle so the request drops right after it.
    assign abort = (state_q != StIdle) && mem.mem_waitrequest &&
                   (cnt_q == 16'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT;
    assign abort          = 1'b0;
`endif

    assign any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        ready_d = ready_q;
        error_d = error_q;

        unique case (state_q)
            StIdle: begin
                if (take_action_ocimem_a) begin
                    addr_d  = jdo[17 +: ADDR_W];
                    error_d = 1'b0;
                    if (jdo[34]) begin
                        state_d = StRd;
                        ready_d = 1'b0;
                    end
                end else if (take_action_ocimem_b) begin
                    data_d  = jdo[34:3];
                    error_d = 1'b0;
                    state_d = StWr;
                    ready_d = 1'b0;
                end else if (take_no_action_ocimem_a) begin
                    error_d = 1'b0;
                    state_d = StRd;
                    ready_d = 1'b0;
                end
            end
            StRd, StWr: begin
                // Strobes during a transfer are lost; flag it but keep the transfer going.
                if (any_strobe) begin
                    error_d = 1'b1;
                end
                if (!mem.mem_waitrequest) begin
                    if (state_q == StRd) begin
                        data_d = mem.mem_rdata;
                    end
                    addr_d  = addr_q + 1'b1;
                    ready_d = 1'b1;
                    state_d = StIdle;
                end else if (abort) begin
                    error_d = 1'b1;
                    ready_d = 1'b1;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        rd_d = (state_d == StRd);
        wr_d = (state_d == StWr);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            data_q  <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            ready_q <= 1'b1;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            ready_q <= ready_d;
            error_q <= error_d;
        end
    end

    assign mem.mem_addr  = addr_q;
    assign mem.mem_rd    = rd_q;
    assign mem.mem_wr    = wr_q;
    assign mem.mem_wdata = data_q;
    assign MonDReg       = data_q;
    assign monitor_ready = ready_q;
    assign monitor_error = error_q;

endmodule

// File: tb/tb_sistema_cpu_debug_ocimem_sequencer.sv
// Directed + randomized bench for the OCI memory sequencer against a command-level reference model.
module tb_sistema_cpu_debug_ocimem_sequencer;

    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [37:0] jdo;
    logic        ta_a;
    logic        ta_b;
    logic        tna_a;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        monitor_error;

    sistema_cpu_debug_ocimem_sequencer_if #(.ADDR_W(ADDR_W)) mem_bus ();

    sistema_cpu_debug_ocimem_sequencer #(
        .ADDR_W (ADDR_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk                    (clk),
        .reset_n                (reset_n),
        .jdo                    (jdo),
        .take_action_ocimem_a   (ta_a),
        .take_action_ocimem_b   (ta_b),
        .take_no_action_ocimem_a(tna_a),
        .mem                    (mem_bus),
        .MonDReg                (MonDReg),
        .monitor_ready          (monitor_ready),
        .monitor_error          (monitor_error)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: architectural registers only, updated per command outcome.
    logic [ADDR_W-1:0] m_addr;
    logic [31:0]       m_data;
    logic              m_error;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_rd"},    64'(mem_bus.mem_rd),   64'd0);
        check({tag, "_wr"},    64'(mem_bus.mem_wr),   64'd0);
        check({tag, "_ready"}, 64'(monitor_ready),    64'd1);
        check({tag, "_error"}, 64'(monitor_error),    64'(m_error));
        check({tag, "_dreg"},  64'(MonDReg),          64'(m_data));
        check({tag, "_addr"},  64'(mem_bus.mem_addr), 64'(m_addr));
    endtask

    function automatic logic [37:0] rnd_jdo();
        logic [37:0] j;
        j = {6'($urandom), $urandom};
        return j;
    endfunction

    function automatic logic [37:0] mk_load(input logic [ADDR_W-1:0] addr, input logic rd);
        logic [37:0] j;
        j              = rnd_jdo();
        j[17 +: ADDR_W] = addr;
        j[34]          = rd;
        return j;
    endfunction

    function automatic logic [37:0] mk_write(input logic [31:0] data);
        logic [37:0] j;
        j       = rnd_jdo();
        j[34:3] = data;
        return j;
    endfunction

    // Called at a negedge with the DUT idle. inj >= 0 injects a write strobe in that transfer cycle.
    task automatic command(input logic a, input logic b, input logic na, input logic [37:0] j,
                           input int waits, input logic [31:0] rdata, input int inj,
                           input string tag);
        int kind; // 0 none, 1 address load only, 2 read, 3 write
        bit injected;
        jdo   = j;
        ta_a  = a;
        ta_b  = b;
        tna_a = na;
        if (a) begin
            m_addr = j[17 +: ADDR_W];
            kind   = j[34] ? 2 : 1;
        end else if (b) begin
            m_data = j[34:3];
            kind   = 3;
        end else if (na) begin
            kind = 2;
        end else begin
            kind = 0;
        end
        if (kind != 0) m_error = 1'b0;
        @(negedge clk);
        ta_a  = 1'b0;
        ta_b  = 1'b0;
        tna_a = 1'b0;
        jdo   = rnd_jdo();
        if (kind < 2) begin
            check_idle(tag);
            return;
        end
        for (int i = 0; i <= waits; i++) begin
            check({tag, "_req_rd"}, 64'(mem_bus.mem_rd),   64'(kind == 2));
            check({tag, "_req_wr"}, 64'(mem_bus.mem_wr),   64'(kind == 3));
            check({tag, "_req_addr"}, 64'(mem_bus.mem_addr), 64'(m_addr));
            check({tag, "_busy"},   64'(monitor_ready),    64'd0);
            check({tag, "_berr"},   64'(monitor_error),    64'(m_error));
            if (kind == 3) check({tag, "_wdata"}, 64'(mem_bus.mem_wdata), 64'(m_data));
            mem_bus.mem_waitrequest = (i < waits);
            mem_bus.mem_rdata       = (i < waits) ? $urandom : rdata;
            injected = (i == inj);
            if (injected) begin
                ta_b = 1'b1;
                jdo  = rnd_jdo();
            end
            @(negedge clk);
            ta_b = 1'b0;
            if (injected) m_error = 1'b1;
        end
        mem_bus.mem_waitrequest = 1'b0;
        if (kind == 2) m_data = rdata;
        m_addr = m_addr + 1'b1;
        check_idle(tag);
    endtask

    initial begin
        logic [2:0]  s;
        logic [31:0] rd_val;
        int          w;
        int          inj;

        reset_n                 = 1'b0;
        jdo                     = '0;
        ta_a                    = 1'b0;
        ta_b                    = 1'b0;
        tna_a                   = 1'b0;
        mem_bus.mem_rdata       = '0;
        mem_bus.mem_waitrequest = 1'b0;
        m_addr                  = '0;
        m_data                  = '0;
        m_error                 = 1'b0;
        repeat (2) @(negedge clk);
        check_idle("reset");
        reset_n = 1'b1;
        @(negedge clk);
        check_idle("post_reset");

        command(1'b1, 1'b0, 1'b0, mk_load(8'h10, 1'b1), 0, 32'hDEADBEEF, -1, "load_rd");
        check("load_rd_addr11", 64'(mem_bus.mem_addr), 64'h11);

        command(1'b1, 1'b0, 1'b0, mk_load(8'hFF, 1'b0), 0, 32'h0, -1, "load_ff");
        command(1'b0, 1'b1, 1'b0, mk_write(32'h12345678), 3, 32'h0, -1, "wr_wrap");
        check("wr_wrap_addr0", 64'(mem_bus.mem_addr), 64'h0);

        for (int k = 0; k < 3; k++) begin
            command(1'b0, 1'b0, 1'b1, rnd_jdo(), 0, $urandom, -1, "rd_seq");
        end

        command(1'b0, 1'b0, 1'b1, rnd_jdo(), 3, 32'hCAFEF00D, 1, "rd_drop");
        check("rd_drop_err", 64'(monitor_error), 64'd1);
        command(1'b1, 1'b1, 1'b0, mk_load(8'h40, 1'b0), 0, 32'h0, -1, "a_and_b");
        check("a_and_b_err_clr", 64'(monitor_error), 64'd0);

        for (int k = 0; k < 24; k++) begin
            s      = 3'($urandom_range(1, 7));
            w      = int'($urandom_range(0, 3));
            inj    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, w)) : -1;
            rd_val = $urandom;
            command(s[0], s[1], s[2], rnd_jdo(), w, rd_val, inj, "rand");
        end

        // Permanently stalled read.
        tna_a   = 1'b1;
        m_error = 1'b0;
        @(negedge clk);
        tna_a                   = 1'b0;
        mem_bus.mem_waitrequest = 1'b1;
`ifdef SISTEMA_OCIMEM_TIMEOUT_EN
        for (int i = 0; i < int'(TIMEOUT); i++) begin
            check("tmo_req", 64'(mem_bus.mem_rd), 64'd1);
            @(negedge clk);
        end
        m_error = 1'b1;
        check_idle("timeout");
        tna_a = 1'b1;
        @(negedge clk);
        tna_a = 1'b0;
        @(negedge clk);
`else
        repeat (1000) @(negedge clk);
        check("hang_req",   64'(mem_bus.mem_rd),   64'd1);
        check("hang_ready", 64'(monitor_ready),    64'd0);
        check("hang_addr",  64'(mem_bus.mem_addr), 64'(m_addr));
`endif

        // Asynchronous reset in the middle of a stalled read.
        check("pre_rst_req", 64'(mem_bus.mem_rd), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        m_addr  = '0;
        m_data  = '0;
        m_error = 1'b0;
        check_idle("async_rst");
        mem_bus.mem_waitrequest = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        command(1'b0, 1'b0, 1'b1, rnd_jdo(), 1, 32'h0BADC0DE, -1, "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sistema_cpu_debug_ocimem_sequencer.md
# sistema_cpu_debug_ocimem_sequencer

System-clock-domain controller that turns the debug slave's decoded JTAG strobes (`take_action_ocimem_a/b`, `take_no_action_ocimem_a`) and the `jdo` payload into single-beat read/write transactions on the CPU's on-chip debug memory port. It holds the monitor address register with post-increment and returns read data in `MonDReg`. It reports completion and faults back to the debug slave through `monitor_ready` and `monitor_error`. It sits between the debug slave wrapper's sysclk outputs and the OCI RAM/register file.

## Interface
Parameters:
- `ADDR_W`, default 8: word-address width of the memory port. The address wraps modulo 2^ADDR_W.
- `TIMEOUT`, default 255: maximum number of wait-request cycles before abort, valid range 1..65535. Used only when `SISTEMA_OCIMEM_TIMEOUT_EN` is defined.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous active-low reset.
- `jdo` in 38: JTAG data payload, sampled only in the cycle of an accepted strobe.
- `take_action_ocimem_a` in 1: load-address command.
- `take_action_ocimem_b` in 1: write command.
- `take_no_action_ocimem_a` in 1: read-next command.
- `mem_addr` out ADDR_W: word address; equals `MonAReg`.
- `mem_rd` out 1: read request.
- `mem_wr` out 1: write request.
- `mem_wdata` out 32: write data.
- `mem_rdata` in 32: read data, valid in the cycle `mem_rd` is high and `mem_waitrequest` is low.
- `mem_waitrequest` in 1: stall for the current request.
- `MonDReg` out 32: last read data or last write data.
- `monitor_ready` out 1: high when the sequencer is idle and the last command has completed.
- `monitor_error` out 1: sticky fault flag.

## Operation
- State machine: IDLE, RD, WR.
- Strobes are accepted only in IDLE. If more than one strobe is high in the same cycle, priority is `take_action_ocimem_a` > `take_action_ocimem_b` > `take_no_action_ocimem_a`; the lower-priority strobes are ignored with no error.
- `take_action_ocimem_a`:
  - `MonAReg <= jdo[17+ADDR_W-1:17]`.
  - If `jdo[34]` = 1, go to RD.
  - Otherwise stay in IDLE; `monitor_ready` stays 1.
- `take_action_ocimem_b`: `MonDReg <= jdo[34:3]`, go to WR.
- `take_no_action_ocimem_a`: go to RD.
- Any accepted command clears `monitor_error`. Any command that enters RD or WR drops `monitor_ready` to 0 in the next cycle.
- RD state:
  - `mem_rd` = 1.
  - When `mem_waitrequest` = 0: `MonDReg <= mem_rdata`, `MonAReg <= MonAReg+1`, `monitor_ready <= 1`, go to IDLE.
- WR state:
  - `mem_wr` = 1, `mem_wdata` = `MonDReg`.
  - When `mem_waitrequest` = 0: `MonAReg <= MonAReg+1`, `monitor_ready <= 1`, go to IDLE.
- Address increment wraps from 2^ADDR_W−1 to 0 with no error.
- A strobe arriving while in RD or WR is dropped and sets `monitor_error` to 1. The transaction in flight is unaffected.
- `mem_rd` and `mem_wr` are never high simultaneously. Both are registered outputs.
- Reset values: state IDLE, `MonAReg` 0, `MonDReg` 0, `mem_rd` 0, `mem_wr` 0, `monitor_ready` 1, `monitor_error` 0.
- Reset asserted mid-transaction drops the request immediately (asynchronously) with no completion.

## Timing
- Strobe accepted at cycle N: `mem_rd`/`mem_wr` is high from N+1.
- With `mem_waitrequest` = 0 at N+1:
  - `MonDReg`, `MonAReg` and `monitor_ready` update at N+2.
  - Request is low at N+2.
  - Minimum command-to-ready latency is 2 cycles.
- Each wait-request cycle adds exactly 1 cycle of latency.
- A new strobe is acceptable at the cycle `monitor_ready` returns to 1.
- A load-address command without a read completes in 1 cycle: `MonAReg` is valid at N+1.

## Configuration
- `SISTEMA_OCIMEM_TIMEOUT_EN` defined:
  - A 16-bit counter clears on entry to RD/WR and increments each cycle `mem_waitrequest` = 1.
  - When the count reaches `TIMEOUT`: deassert the request, set `monitor_error` = 1, set `monitor_ready` = 1, leave `MonDReg` and `MonAReg` unchanged, return to IDLE.
- `SISTEMA_OCIMEM_TIMEOUT_EN` undefined:
  - No counter; the sequencer waits indefinitely.
  - `monitor_error` is set only by dropped strobes.

## Test plan
- Reset, then `take_action_ocimem_a` with address field 0x10 and `jdo[34]`=1, `mem_rdata`=0xDEADBEEF, no wait → `mem_rd` high at N+1 with `mem_addr`=0x10; `MonDReg`=0xDEADBEEF, `monitor_ready`=1, `MonAReg`=0x11 at N+2.
- Write 0x12345678 at address 0xFF with 3 wait cycles → `mem_wr` high for 4 cycles with `mem_wdata`=0x12345678; ready at N+5; `MonAReg` wraps to 0x00.
- Three `take_no_action_ocimem_a` back-to-back, each issued on ready → reads at addresses A, A+1, A+2; `MonDReg` tracks each `mem_rdata`.
- `take_action_ocimem_b` issued while RD is stalled → write dropped, `monitor_error`=1, read completes normally; the next accepted command clears `monitor_error`.
- `take_action_ocimem_a` and `take_action_ocimem_b` in the same cycle → only the address is loaded, no `mem_wr`, no error.
- With `SISTEMA_OCIMEM_TIMEOUT_EN` defined and `TIMEOUT`=4, `mem_waitrequest` held high → request drops after 4 wait cycles, `monitor_error`=1, `monitor_ready`=1, `MonAReg` unchanged. Without the macro, the same stimulus → still waiting after 1000 cycles.
